// File: rtl/rlbp_frame_rx.sv
// rtl/rlbp_frame_rx.sv - rlbp serial frame receiver with word FIFO and Wishbone slave
// Optional per-word even parity bit: define RLBP_RX_PARITY_EN.
module rlbp_frame_rx #(
   parameter int          WORD_W     = 12,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0100
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        ser_start,
   input  logic        ser_clk,
   input  logic        ser_data,
   input  logic        ser_done,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
`ifdef RLBP_RX_PARITY_EN
   localparam int NBITS = WORD_W + 1;
`else
   localparam int NBITS = WORD_W;
`endif
   localparam int BW = $clog2(NBITS);

   typedef enum logic {IDLE, SHIFT} state_t;

   // synchronizer order: {done, data, clk, start}
   logic [3:0] sync1, sync2;
   logic [2:0] prev;
   logic       start_rise, clk_rise, done_rise, bit_in;

   state_t            state_q, state_d;
   logic [BW-1:0]     bitcnt_q, bitcnt_d;
   logic [NBITS-2:0]  shreg_q, shreg_d;
   logic [NBITS-1:0]  sh_full;
   logic              push, short_set, fd_set, par_set;
   logic [WORD_W-1:0] push_word;

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              full, empty, pop, push_ok, ovf_set;

   logic ctrl_en, irq_en, flush_q;
   logic ovf, short_err, frame_done, par_err;
   logic req, wr_stat, sel_data, sel_stat, sel_ctrl;
   logic [31:0] rd_mux, status;
   logic unused_ok;

   assign unused_ok = &{1'b0, wbs_sel_i, wbs_dat_i[31:10], wbs_dat_i[5:3]};

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {ser_done, ser_data, ser_clk, ser_start};
         sync2 <= sync1;
         prev  <= {sync2[3], sync2[1], sync2[0]};
      end
   end

   assign start_rise = sync2[0] & ~prev[0];
   assign clk_rise   = sync2[1] & ~prev[1];
   assign done_rise  = sync2[3] & ~prev[2];
   assign bit_in     = sync2[2];
   assign sh_full    = {shreg_q, bit_in};

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shreg_q  <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      push      = 1'b0;
      push_word = sh_full[NBITS-1:NBITS-WORD_W];
      short_set = 1'b0;
      fd_set    = 1'b0;
      par_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_rise && ctrl_en) begin
               bitcnt_d = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (!ctrl_en) begin
               bitcnt_d = '0;
               state_d  = IDLE;
            end else if (start_rise) begin
               bitcnt_d  = '0;
               short_set = 1'b1;
            end else if (done_rise) begin
               short_set = (bitcnt_q != '0);
               fd_set    = 1'b1;
               bitcnt_d  = '0;
               state_d   = IDLE;
            end else if (clk_rise) begin
               if (bitcnt_q == BW'(NBITS - 1)) begin
                  bitcnt_d = '0;
`ifdef RLBP_RX_PARITY_EN
                  // even parity over word plus parity bit must be zero
                  par_set = ^sh_full;
                  push    = ~(^sh_full);
`else
                  push = 1'b1;
`endif
               end else begin
                  shreg_d  = sh_full[NBITS-2:0];
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign sel_data = (wbs_adr_i == BASE_ADDR);
   assign sel_stat = (wbs_adr_i == BASE_ADDR + 32'h4);
   assign sel_ctrl = (wbs_adr_i == BASE_ADDR + 32'h8);
   assign pop     = req & ~wbs_we_i & sel_data & ~empty;
   assign push_ok = push & (~full | pop);
   assign ovf_set = push & full & ~pop;
   assign wr_stat = req & wbs_we_i & sel_stat;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_q) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

   assign status = {21'b0, (state_q != IDLE), par_err, frame_done, short_err,
                    ovf, full, empty, 4'(count)};

   always_comb begin
      rd_mux = '0;
      if (sel_data && !empty) rd_mux = {{(32-WORD_W){1'b0}}, mem[rd_ptr]};
      else if (sel_stat)      rd_mux = status;
      else if (sel_ctrl)      rd_mux = {29'b0, flush_q, irq_en, ctrl_en};
   end

   // sticky flags: a same-cycle set beats the W1C clear
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         ctrl_en    <= 1'b0;
         irq_en     <= 1'b0;
         flush_q    <= 1'b0;
         ovf        <= 1'b0;
         short_err  <= 1'b0;
         frame_done <= 1'b0;
         par_err    <= 1'b0;
      end else begin
         wbs_ack_o <= req;
         if (req && !wbs_we_i) wbs_dat_o <= rd_mux;
         flush_q <= 1'b0;
         if (req && wbs_we_i && sel_ctrl) begin
            ctrl_en <= wbs_dat_i[0];
            irq_en  <= wbs_dat_i[1];
            flush_q <= wbs_dat_i[2];
         end
         ovf        <= (ovf        & ~(wr_stat & wbs_dat_i[6])) | ovf_set;
         short_err  <= (short_err  & ~(wr_stat & wbs_dat_i[7])) | short_set;
         frame_done <= (frame_done & ~(wr_stat & wbs_dat_i[8])) | fd_set;
         par_err    <= (par_err    & ~(wr_stat & wbs_dat_i[9])) | par_set;
      end
   end

   assign irq = frame_done & irq_en;

endmodule

// File: tb/tb_rlbp_frame_rx.sv
// tb/tb_rlbp_frame_rx.sv - scoreboard testbench for rlbp_frame_rx
module tb_rlbp_frame_rx;

   localparam logic [31:0] BASE  = 32'h3000_0100;
   localparam logic [31:0] A_DAT = BASE;
   localparam logic [31:0] A_STA = BASE + 32'h4;
   localparam logic [31:0] A_CTL = BASE + 32'h8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ser_start = 1'b0, ser_clk = 1'b0, ser_data = 1'b0, ser_done = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dat_i = '0;
   logic [3:0]  sel = 4'hF;
   logic        ack;
   logic [31:0] dat_o;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   rlbp_frame_rx dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .ser_start(ser_start), .ser_clk(ser_clk), .ser_data(ser_data), .ser_done(ser_done),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
      .wbs_dat_i(dat_i), .wbs_sel_i(sel), .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq(irq)
   );

   always #5 clk = ~clk;

   // read-data monitor
   always @(negedge clk) begin
      if (ack && !we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: got 0x%0h with no expected entry", dat_o);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            automatic string nm = name_q.pop_front();
            if (dat_o !== e) begin
               errors++;
               $display("FAIL %s: got 0x%0h expected 0x%0h", nm, dat_o, e);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // all tasks start and end #1 after a rising edge
   task automatic wait_ack(output logic ok);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 20);
      ok = ack;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wb_ack_timeout: got no ack expected ack within 20 cycles");
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input string nm, input logic [31:0] a, input logic [31:0] e);
      logic ok;
      exp_q.push_back(e);
      name_q.push_back(nm);
      adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      wait_ack(ok);
      if (!ok) begin
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      logic ok;
      adr = a; dat_i = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      wait_ack(ok);
   endtask

   task automatic pulse_start();
      ser_start = 1'b1; repeat (4) @(posedge clk); #1;
      ser_start = 1'b0; repeat (4) @(posedge clk); #1;
   endtask

   task automatic pulse_done();
      ser_done = 1'b1; repeat (4) @(posedge clk); #1;
      ser_done = 1'b0; repeat (5) @(posedge clk); #1;
   endtask

   task automatic send_raw(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ser_data = v[i]; ser_clk = 1'b0;
         repeat (4) @(posedge clk); #1;
         ser_clk = 1'b1;
         repeat (4) @(posedge clk); #1;
         ser_clk = 1'b0;
      end
   endtask

   task automatic word_bits(input logic [11:0] w, output logic [15:0] v, output int n);
`ifdef RLBP_RX_PARITY_EN
      v = {3'b0, w, ^w}; n = 13;
`else
      v = {4'b0, w}; n = 12;
`endif
   endtask

   task automatic send_word(input logic [11:0] w);
      logic [15:0] v;
      int n;
      word_bits(w, v, n);
      send_raw(v, n);
   endtask

   initial begin
      logic [15:0] v;
      int n;

      repeat (3) @(posedge clk); #1;
      check("reset_ack", {31'b0, ack}, 32'h0);
      check("reset_dat", dat_o, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      wb_read("reset_status", A_STA, 32'h010);
      wb_read("reset_ctrl", A_CTL, 32'h0);

      // two-word frame, irq
      wb_write(A_CTL, 32'h3);
      wb_read("ctrl_rb", A_CTL, 32'h3);
      pulse_start();
      wb_read("busy_status", A_STA, 32'h410);
      send_word(12'hA5C);
      send_word(12'h3F1);
      pulse_done();
      wb_read("frame_status", A_STA, 32'h102);
      check("irq_on", {31'b0, irq}, 32'h1);
      wb_read("data0", A_DAT, 32'hA5C);
      wb_read("data1", A_DAT, 32'h3F1);
      wb_read("empty_status", A_STA, 32'h110);
      wb_write(A_STA, 32'h100);
      check("irq_off", {31'b0, irq}, 32'h0);
      wb_read("empty_pop", A_DAT, 32'h0);
      wb_read("after_pop_status", A_STA, 32'h010);
      wb_write(BASE + 32'hC, 32'hFFFF_FFFF);
      wb_read("unmapped", BASE + 32'hC, 32'h0);

      // overflow
      pulse_start();
      for (int i = 0; i < 9; i++) send_word(12'h100 + 12'(i));
      pulse_done();
      wb_read("ovf_status", A_STA, 32'h168);
      for (int i = 0; i < 8; i++) wb_read("ovf_data", A_DAT, 32'h100 + i);
      wb_read("ovf_drained", A_STA, 32'h150);
      wb_write(A_STA, 32'h1C0);
      wb_read("ovf_cleared", A_STA, 32'h010);

      // short frame
      pulse_start();
      send_raw(16'h15, 5);
      pulse_done();
      wb_read("short_status", A_STA, 32'h190);
      wb_write(A_STA, 32'h80);
      wb_read("short_cleared", A_STA, 32'h110);
      wb_write(A_STA, 32'h100);

      // flush
      pulse_start();
      send_word(12'h111);
      send_word(12'h222);
      pulse_done();
      wb_read("pre_flush", A_STA, 32'h102);
      wb_write(A_CTL, 32'h7);
      wb_read("post_flush", A_STA, 32'h110);
      wb_read("flush_selfclr", A_CTL, 32'h3);
      wb_write(A_STA, 32'h100);

      // full FIFO, DATA pop lands on the 9th push edge
      pulse_start();
      for (int i = 0; i < 8; i++) send_word(12'h200 + 12'(i));
      word_bits(12'h208, v, n);
      send_raw(v >> 1, n - 1);
      ser_data = v[0]; ser_clk = 1'b0;
      repeat (4) @(posedge clk); #1;
      ser_clk = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      wb_read("coinc_data", A_DAT, 32'h200);
      repeat (2) @(posedge clk); #1;
      ser_clk = 1'b0;
      pulse_done();
      wb_read("coinc_status", A_STA, 32'h128);
      for (int i = 1; i < 9; i++) wb_read("coinc_drain", A_DAT, 32'h200 + i);
      wb_write(A_STA, 32'h100);

      // reset during the 7th bit
      pulse_start();
      send_word(12'h7E7);
      send_raw(16'h2A, 6);
      ser_data = 1'b1; ser_clk = 1'b0;
      repeat (2) @(posedge clk); #1;
      wb_read("pre_reset", A_STA, 32'h401);
      rst_n = 1'b0;
      #2;
      check("mid_reset_ack", {31'b0, ack}, 32'h0);
      check("mid_reset_dat", dat_o, 32'h0);
      check("mid_reset_irq", {31'b0, irq}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      wb_read("post_reset_status", A_STA, 32'h010);
      wb_write(A_CTL, 32'h1);
      pulse_start();
      send_word(12'h001);
      pulse_done();
      wb_read("rst_frame_status", A_STA, 32'h101);
      wb_read("rst_frame_data", A_DAT, 32'h001);
      wb_read("rst_frame_empty", A_STA, 32'h110);
      wb_write(A_STA, 32'h100);

`ifdef RLBP_RX_PARITY_EN
      pulse_start();
      send_raw(16'h1FF, 13);
      send_raw(16'h1FE, 13);
      pulse_done();
      wb_read("par_status", A_STA, 32'h301);
      wb_read("par_data", A_DAT, 32'h0FF);
      wb_write(A_STA, 32'h300);
      wb_read("par_cleared", A_STA, 32'h010);
`endif

      repeat (3) @(posedge clk); #1;
      check("scoreboard_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rlbp_frame_rx.md
# rlbp_frame_rx

Capture-side counterpart of the rlbp readout controller's serial frame output. It receives the `start_o` / `clk_o` / `data_o` / `done_o` stream, deserializes it into LBP code words and buffers them in a small FIFO. The buffered words are exposed to the management SoC as a Wishbone slave, with a frame-done interrupt. The block sits inside the user project next to `rlbp_macro`, in the `vccd1` digital domain.

## Interface
Parameters:
- `WORD_W`, 12: bits per LBP code word (one per photodiode).
- `FIFO_DEPTH`, 8: word buffer depth; must be a power of two.
- `BASE_ADDR`, 32'h3000_0100: Wishbone base address. Registers are at +0x0 DATA, +0x4 STATUS, +0x8 CTRL.

Ports:
- `wb_clk_i`  in  1  system clock; all logic on its rising edge.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `ser_start`  in  1  frame start from the transmitter's `start_o`; asynchronous to `wb_clk_i`.
- `ser_clk`  in  1  bit clock from `clk_o`; sampled, never used as a clock.
- `ser_data`  in  1  serial data from `data_o`; valid at the `ser_clk` rising edge.
- `ser_done`  in  1  frame end from `done_o`.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  Wishbone control.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_sel_i`  in  4  byte selects; ignored, every write is a full word.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `wbs_dat_o`  out  32  read data.
- `irq`  out  1  level interrupt = `frame_done & irq_en`.

## Operation
- All four `ser_*` inputs pass through 2-flop synchronizers. A rise detector on the synchronized start, clk and done produces one-cycle pulses.
- FSM states:
  - IDLE: on a start rise with `CTRL.en`=1, clear the bit counter and go to SHIFT.
  - SHIFT: each clk rise shifts in the synchronized data bit, MSB first, and increments `bitcnt`. When `bitcnt` reaches `WORD_W`, push the word and clear `bitcnt`.
  - SHIFT, done rise: if `bitcnt`≠0, discard the partial word and set sticky `short_err`. Then set sticky `frame_done` and return to IDLE.
- A start rise while in SHIFT restarts the frame: the partial word is discarded and `short_err` is set.
- Clearing `CTRL.en` while in SHIFT returns the FSM to IDLE immediately; the partial word is lost and no flag is set.
- FIFO:
  - A push while full drops the word and sets sticky `ovf`.
  - A push and a pop in the same cycle while full both succeed, with no overflow.
  - A pop while empty returns 0 with no side effect.
- Registers:
  - DATA (read-only): `{ (32-WORD_W)'0, head }`. A read pops one word.
  - STATUS: `[3:0]` count, `[4]` empty, `[5]` full, `[6]` ovf, `[7]` short_err, `[8]` frame_done, `[9]` par_err, `[10]` busy (FSM≠IDLE). Writing 1 to bits 6–9 clears that bit.
  - CTRL (R/W): `[0]` en, `[1]` irq_en, `[2]` flush. flush is self-clearing and empties the FIFO in the cycle after the write.
  - An unmapped address reads 0 and writes are ignored; it is still acked.
- When a set and a W1C clear of a sticky bit land in the same cycle, the set wins.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0, FSM=IDLE, FIFO empty, all flags 0, CTRL=0.
- Minimum `ser_clk` high time and low time: 3 `wb_clk_i` cycles each.
- Latency from a `ser_clk` pin edge to the bit being shifted in: 3 cycles.
- A pushed word is visible in STATUS.count 1 cycle after the last bit is shifted.
- Wishbone: `wbs_ack_o` rises 1 cycle after `cyc&stb` and stays high for exactly 1 cycle. `wbs_dat_o` is valid in the ack cycle. The DATA pop takes effect on the ack edge.
- A back-to-back request (stb held high) is acked every other cycle.
- Asserting reset mid-frame clears everything asynchronously. After release, the FSM waits for the next start rise.

## Configuration
- `RLBP_RX_PARITY_EN`:
  - Defined: each word is followed by one even-parity bit (WORD_W+1 bits per word). On a parity mismatch the word is dropped and sticky `par_err` is set.
  - Undefined: exactly `WORD_W` bits per word, and STATUS[9] reads 0.

## Test plan
- en=1; send a frame of words 0xA5C, 0x3F1, then done -> count=2; DATA reads 0xA5C then 0x3F1; frame_done=1; `irq`=1 when irq_en=1.
- Send 9 words into a depth-8 FIFO -> count=8, full=1, ovf=1; the first 8 words read back in order.
- Send 5 bits then done -> count=0, short_err=1; a write of 0x80 to STATUS clears it.
- Full FIFO, with a DATA read coinciding with the 9th push -> ovf=0 and count stays 8.
- Assert reset during the 7th bit, release, then send 0x001 -> exactly one word, 0x001; all flags 0.
- With `RLBP_RX_PARITY_EN`: 0x0FF with parity 1 -> dropped, par_err=1; 0x0FF with parity 0 -> stored.
